// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, burst-bounded arbiter sharing one UART transmitter
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_BURST   = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic                          active,
  output logic                          err_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int WD_W  = $clog2(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RELEASE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] byte_cnt;
  logic [WD_W-1:0]  wdog;
  logic             last_q;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             burst_end;
  logic [IDX_W-1:0] ptr_next;
  logic [NUM_REQ-1:0] one_lsb;

  assign one_lsb   = {{(NUM_REQ-1){1'b0}}, 1'b1};
  assign burst_end = last_q || (byte_cnt == CNT_W'(MAX_BURST));
  assign ptr_next  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

  // First requester at or after ptr, wrapping around.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      owner       <= '0;
      byte_cnt    <= '0;
      wdog        <= '0;
      last_q      <= 1'b0;
      req_ack     <= '0;
      gnt         <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            gnt      <= one_lsb << win_idx;
            owner    <= win_idx;
            byte_cnt <= '0;
            state    <= S_LAUNCH;
            active   <= 1'b1;
          end
        end
        S_LAUNCH: begin
          if (req[owner]) begin
            tx_data  <= req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
            tx_valid <= 1'b1;
            req_ack  <= one_lsb << owner;
            last_q   <= req_last[owner];
            byte_cnt <= byte_cnt + CNT_W'(1);
            wdog     <= '0;
            state    <= S_WAIT_BUSY;
          end else begin
            state <= S_RELEASE;
          end
        end
        S_WAIT_BUSY: begin
          // A done seen before busy means the whole frame fit between samples.
          if (tx_done) begin
            tx_valid <= 1'b0;
            state    <= burst_end ? S_RELEASE : S_LAUNCH;
          end else if (tx_busy) begin
            tx_valid <= 1'b0;
            state    <= S_WAIT_DONE;
          end else if (wdog == WD_W'(ACK_TIMEOUT - 1)) begin
            tx_valid    <= 1'b0;
            err_timeout <= 1'b1;
            state       <= S_RELEASE;
          end else if (wdog != '1) begin
            wdog <= wdog + WD_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (tx_done) begin
            state <= burst_end ? S_RELEASE : S_LAUNCH;
          end
        end
        S_RELEASE: begin
          gnt      <= '0;
          ptr      <= ptr_next;
          byte_cnt <= '0;
          state    <= S_IDLE;
          active   <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between NUM_REQ byte producers using round-robin arbitration with bounded bursts. It drives the transmitter's data/dataValid inputs, tracks its busy/done outputs, and returns a per-byte acknowledge to the owning requester. It sits between the producers (command engine, debug port, etc.) and the UART TX top level. A watchdog flags a transmitter that never accepts a launched byte.

Parameters:
NUM_REQ, 4, number of requesters (>=2).
DATA_WIDTH, 8, byte width passed to the transmitter.
MAX_BURST, 4, maximum bytes sent per grant before rotation (>=1).
ACK_TIMEOUT, 64, cycles to wait for tx_busy after launch before flagging an error (>=2).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset. Synchronous, active-high.
req  in  NUM_REQ  requester i has a byte pending on req_data slice i.
req_data  in  NUM_REQ*DATA_WIDTH  packed; requester i uses [i*DATA_WIDTH +: DATA_WIDTH].
req_last  in  NUM_REQ  slice i's current byte ends its burst.
req_ack  out  NUM_REQ  one-cycle one-hot pulse: byte from requester i was captured.
gnt  out  NUM_REQ  one-hot current owner, 0 when no owner.
tx_data  out  DATA_WIDTH  registered byte to the transmitter.
tx_valid  out  1  launch request to the transmitter (its dataValid).
tx_busy  in  1  transmitter busy.
tx_done  in  1  transmitter end-of-frame pulse.
active  out  1  high whenever state != IDLE.
err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, byte_cnt 0, wdog 0. Reset has priority over every event in every state, including mid-frame. The transmitter is not aborted; its own reset governs it.
- All outputs are registered.
- Round-robin search runs over indices ptr, ptr+1, …, ptr+NUM_REQ-1 (mod NUM_REQ). The first index with req=1 wins.
- IDLE: if |req, then gnt<=onehot(winner), owner<=winner, byte_cnt<=0, go to LAUNCH. Otherwise stay.
- LAUNCH:
  - If req[owner]=1: tx_data<=req_data slice, tx_valid<=1, req_ack<=onehot(owner) for 1 cycle, last_q<=req_last[owner], byte_cnt<=byte_cnt+1, wdog<=0, go to WAIT_BUSY.
  - If req[owner]=0: no ack, go to RELEASE.
- WAIT_BUSY: tx_valid held high; wdog increments each cycle.
  - tx_busy=1: tx_valid<=0, go to WAIT_DONE.
  - tx_done=1 seen here: treated as busy followed by done; take the WAIT_DONE exit directly.
  - wdog reaches ACK_TIMEOUT-1 with no busy: tx_valid<=0, err_timeout<=1, go to RELEASE.
- WAIT_DONE: on tx_done=1:
  - If last_q or byte_cnt==MAX_BURST, go to RELEASE.
  - Else go to LAUNCH.
  - The next launch occurs no earlier than 1 cycle after done, while the transmitter is back in its idle state.
- RELEASE: gnt<=0, ptr<=(owner+1) mod NUM_REQ, byte_cnt<=0, go to IDLE. One bubble cycle is mandatory.
- Latency: req rises in IDLE at edge k → gnt at k+1 → tx_valid and req_ack at k+2. Inter-byte gap within a burst is 1 cycle after tx_done.
- Requesters may change req/req_data only after their req_ack pulse. Data is sampled only in LAUNCH.
- Changes to req of non-owners never affect the current grant.
- err_timeout clears only on rst. Arbitration continues after a timeout.
- Widths: byte_cnt is $clog2(MAX_BURST+1) bits. wdog is $clog2(ACK_TIMEOUT) bits and saturates; no wrap.
- active = (state != IDLE).

Test Plan:
1. After rst, req=0001, data0=0xA5, last0=1; transmitter model busy for 10 cycles → gnt=0001 at k+1; tx_valid=1, tx_data=0xA5, req_ack=0001 at k+2; tx_valid drops the cycle after busy; gnt=0 after done; ptr=1.
2. req=0101 from reset, both last=1, req0 re-asserted after its ack → service order is 0, 2, 0; gnt never holds two bits.
3. MAX_BURST=4; req1 streams 6 bytes 0x10..0x15 with last=0; req3 pending 0xEE → bytes 0x10..0x13 sent, then 0xEE, then 0x14, 0x15.
4. ACK_TIMEOUT=8, tx_busy tied 0 → tx_valid high for exactly 8 cycles, then err_timeout=1 and gnt=0. A following req2 byte is still served; err_timeout remains 1 until rst.
5. Owner drops req after a non-last byte → LAUNCH to RELEASE with no req_ack and no tx_valid; the next requester is granted.
6. rst pulsed during WAIT_DONE → next cycle gnt=0, tx_valid=0, active=0, ptr=0; a subsequent tx_done is ignored.
